// File: rtl/dmem_wait_responder_if.sv
// Load/store port between the core MEM stage and the data-memory responder.
interface dmem_wait_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Word-addressed data RAM behind a valid/ready request/response port with a fixed,
// programmable number of wait cycles between request accept and response.
module dmem_wait_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  dmem_wait_responder_if.slave bus
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES > 15) begin : gen_wait_cycles_err
    $error("WAIT_CYCLES must be in 0..15");
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : gen_addr_w_err
    $error("ADDR_W must be in 1..29");
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [31:0] mem [Depth];

  logic              accept;
  logic              go_resp;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_wmask;
  logic              cur_err;
  logic [ADDR_W-1:0] cur_idx;
  logic              write_en;

  // Current access: live request when completing straight from IDLE, latched copy otherwise.
  always_comb begin
    accept    = (state_q == StIdle) && req_ready_q && bus.req_valid;
    go_resp   = ((state_q == StIdle) && accept && (WaitInit == 4'd0)) ||
                ((state_q == StWait) && (cnt_q == 4'd1));
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_wmask = wmask_q;
    if (state_q == StIdle) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_wmask = bus.req_wmask;
    end
    cur_err  = (cur_addr[1:0] != 2'b00) || (cur_addr[31:ADDR_W+2] != '0);
    cur_idx  = cur_addr[ADDR_W+1:2];
    write_en = go_resp && cur_we && !cur_err;
  end

  // RAM array: byte-lane write on the transition into RESP; never cleared by reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_wmask[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wmask_q      <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'd0;
          resp_err_q   <= 1'b0;
          if (accept) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            wmask_q     <= bus.req_wmask;
            cnt_q       <= WaitInit;
            req_ready_q <= 1'b0;
            if (go_resp) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= cur_err;
              resp_rdata_q <= (!cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
            end else begin
              state_q <= StWait;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (go_resp) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_err_q   <= cur_err;
            resp_rdata_q <= (!cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench: main instance with two wait cycles, second instance with none.
module tb_dmem_wait_responder;

  localparam int unsigned AW = 10;
  localparam int unsigned WC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_wait_responder_if bus ();
  dmem_wait_responder_if bus0 ();

  dmem_wait_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  dmem_wait_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       sb_q[$];
  resp_t       sb0_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] shadow [2**AW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one access; updates the shadow RAM for good stores.
  function automatic resp_t model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wmask);
    resp_t r;
    logic [AW-1:0] idx;
    r.err   = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
    r.rdata = 32'd0;
    idx     = addr[AW+1:2];
    if (!r.err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) if (wmask[b]) shadow[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        r.rdata = shadow[idx];
      end
    end
    return r;
  endfunction

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask, input int hold);
    int          n;
    int          lat;
    resp_t       exp;
    logic [31:0] rd_hold;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    sb_q.push_back(model(we, addr, wdata, wmask));
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(WC + 1));
    rd_hold = bus.resp_rdata;
    for (int i = 0; i < hold; i++) begin
      // Conflicting store presented while busy must be ignored.
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h10;
      bus.req_wdata = 32'h5555_5555;
      bus.req_wmask = 4'hf;
      @(negedge clk);
      check({tag, " hold valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, " hold rdata"}, bus.resp_rdata, rd_hold);
      check({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check({tag, " rdata"}, bus.resp_rdata, exp.rdata);
      check({tag, " err"}, 32'(bus.resp_err), 32'(exp.err));
    end
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    check({tag, " post valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " post req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_req0(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
    int    n;
    int    lat;
    resp_t exp;
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    bus0.req_wmask = 4'hf;
    n = 0;
    while (!bus0.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready"}, 32'(bus0.req_ready), 32'd1);
    sb0_q.push_back('{rdata: exp_rdata, err: 1'b0});
    @(negedge clk);
    bus0.req_valid = 1'b0;
    lat = 1;
    while (!bus0.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd1);
    bus0.resp_ready = 1'b1;
    exp = sb0_q.pop_front();
    check({tag, " rdata"}, bus0.resp_rdata, exp.rdata);
    check({tag, " err"}, 32'(bus0.resp_err), 32'(exp.err));
    @(negedge clk);
    bus0.resp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_addr    = 32'd0;
    bus.req_wdata   = 32'd0;
    bus.req_wmask   = 4'd0;
    bus.resp_ready  = 1'b0;
    bus0.req_valid  = 1'b0;
    bus0.req_we     = 1'b0;
    bus0.req_addr   = 32'd0;
    bus0.req_wdata  = 32'd0;
    bus0.req_wmask  = 4'd0;
    bus0.resp_ready = 1'b0;

    // Reset behaviour
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post-rst req_ready", 32'(bus.req_ready), 32'd1);
    check("post-rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("post-rst resp_err", 32'(bus.resp_err), 32'd0);

    // Full-word store/load, byte-lane merge, stall in RESP, empty mask
    do_req("st word", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hf, 0);
    do_req("ld word", 1'b0, 32'h10, 32'h0, 4'h0, 0);
    do_req("st byte", 1'b1, 32'h10, 32'h0000_00AA, 4'h1, 0);
    do_req("ld byte", 1'b0, 32'h10, 32'h0, 4'h0, 0);
    do_req("ld stall", 1'b0, 32'h10, 32'h0, 4'h0, 4);
    do_req("st stall", 1'b1, 32'h14, 32'h0102_0304, 4'hc, 4);
    do_req("ld after stall", 1'b0, 32'h10, 32'h0, 4'h0, 0);
    do_req("ld lanes", 1'b0, 32'h14, 32'h0, 4'h0, 0);
    do_req("st mask0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0);
    do_req("ld mask0", 1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Errors: misaligned load, out-of-range store aliasing word 0
    do_req("ld misalign", 1'b0, 32'h13, 32'h0, 4'h0, 0);
    do_req("st word0", 1'b1, 32'h0, 32'h0BAD_C0DE, 4'hf, 0);
    do_req("st range", 1'b1, 32'(4 << AW), 32'hFFFF_FFFF, 4'hf, 0);
    do_req("ld word0", 1'b0, 32'h0, 32'h0, 4'h0, 0);
    do_req("st top", 1'b1, 32'h0000_0FFC, 32'h7777_8888, 4'hf, 0);
    do_req("ld top", 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 0);

    // Reset during WAIT of a store drops it
    do_req("st 0x20", 1'b1, 32'h20, 32'h1122_3344, 4'hf, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hCAFE_F00D;
    bus.req_wmask = 4'hf;
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid-rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("mid-rst req_ready", 32'(bus.req_ready), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("after mid-rst req_ready", 32'(bus.req_ready), 32'd1);
    check("after mid-rst resp_valid", 32'(bus.resp_valid), 32'd0);
    do_req("ld 0x20", 1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Zero-wait instance
    do_req0("z st", 1'b1, 32'h8, 32'h1234_5678, 32'h0);
    do_req0("z ld", 1'b0, 32'h8, 32'h0, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
